// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared encodings and defaults for the fetch/data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam int unsigned MEM_LAT_DEFAULT    = 1;
    localparam int unsigned STARVE_MAX_DEFAULT = 4;
    localparam int unsigned CNT_W              = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef enum logic [0:0] {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_starve_counter.sv
// ============================================================================
// Module      : mem_arbiter_starve_counter
// Description : Counts data grants taken while a fetch is waiting; flags when
//               the fetch must be given priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter_starve_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
)(
    input  logic clk,
    input  logic rst,
    input  logic if_req_i,
    input  logic fetch_gnt_i,
    input  logic data_gnt_i,
    output logic at_max_o
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (fetch_gnt_i || !if_req_i) begin
            cnt_d = '0;
        end else if (data_gnt_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MAX_C);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester (fetch/data) arbiter in front of a single-port
//               memory with fixed read latency; one access in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT    = MEM_LAT_DEFAULT,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT);

    state_e           state_q,    state_d;
    owner_e           owner_q,    owner_d;
    logic [CNT_W-1:0] lat_cnt_q,  lat_cnt_d;
    logic             is_wr_q,    is_wr_d;
    logic [31:0]      addr_q,     addr_d;
    logic [31:0]      wdata_q,    wdata_d;
    logic             if_gnt_q,   if_gnt_d;
    logic             d_gnt_q,    d_gnt_d;
    logic             if_valid_q, if_valid_d;
    logic             d_valid_q,  d_valid_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic [31:0]      d_rdata_q,  d_rdata_d;
    logic             rd_en_q,    rd_en_d;
    logic             wr_en_q,    wr_en_d;

    logic w_d_req;
    logic w_starve_max;
    logic w_fetch_pick;
    logic w_accept;

    assign w_d_req      = d_rd | d_wr;
    // Data normally wins; a waiting fetch wins once it has been starved long enough.
    assign w_fetch_pick = if_req & (w_starve_max | ~w_d_req);
    assign w_accept     = (state_q == ST_IDLE) & (if_req | w_d_req);

    mem_arbiter_starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req),
        .fetch_gnt_i (w_accept & w_fetch_pick),
        .data_gnt_i  (w_accept & ~w_fetch_pick),
        .at_max_o    (w_starve_max)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lat_cnt_d  = lat_cnt_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_gnt_d   = 1'b0;
        d_gnt_d    = 1'b0;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        rd_en_d    = rd_en_q;
        wr_en_d    = wr_en_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d   = ST_BUSY;
                    lat_cnt_d = LAT_INIT;
                    if (w_fetch_pick) begin
                        owner_d  = OWN_FETCH;
                        is_wr_d  = 1'b0;
                        addr_d   = if_addr;
                        wdata_d  = '0;
                        if_gnt_d = 1'b1;
                        rd_en_d  = 1'b1;
                        wr_en_d  = 1'b0;
                    end else begin
                        owner_d = OWN_DATA;
                        is_wr_d = d_wr;
                        addr_d  = d_addr;
                        wdata_d = d_wr ? d_wdata : '0;
                        d_gnt_d = 1'b1;
                        rd_en_d = ~d_wr;
                        wr_en_d = d_wr;
                    end
                end
            end
            ST_BUSY: begin
                lat_cnt_d = lat_cnt_q - CNT_W'(1);
                if (lat_cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                    if (owner_q == OWN_FETCH) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_valid_d = 1'b1;
                        if (!is_wr_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_FETCH;
            lat_cnt_q  <= '0;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_gnt_q   <= 1'b0;
            d_gnt_q    <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lat_cnt_q  <= lat_cnt_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_gnt_q   <= if_gnt_d;
            d_gnt_q    <= d_gnt_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
        end
    end

    // Latched address/data are only presented while an access is in flight.
    assign mem_addr  = (state_q == ST_BUSY) ? addr_q  : '0;
    assign mem_wdata = (state_q == ST_BUSY) ? wdata_q : '0;
    assign mem_rd_en = rd_en_q;
    assign mem_wr_en = wr_en_q;
    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter (MEM_LAT=1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst3 = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_rd = 1'b0;
    logic        d_wr = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] mem_rdata = '0;

    logic        if_gnt, if_valid, d_gnt, d_valid, mem_rd_en, mem_wr_en;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_gnt3, if_valid3, d_gnt3, d_valid3, mem_rd_en3, mem_wr_en3;
    logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk(clk), .rst(rst3),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3),
        .if_valid(if_valid3), .if_rdata(if_rdata3),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt3), .d_valid(d_valid3), .d_rdata(d_rdata3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rd_en(mem_rd_en3), .mem_wr_en(mem_wr_en3), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] dg_vec;
        logic [11:0] fg_vec;
        logic [5:0]  rd3_vec;
        logic [5:0]  dv3_vec;
        logic [5:0]  fg3_vec;
        logic [5:0]  dg3_vec;
        int          dv_cnt;

        // Reset state
        repeat (3) step();
        check("rst_if_gnt",   {31'd0, if_gnt},    32'd0);
        check("rst_if_valid", {31'd0, if_valid},  32'd0);
        check("rst_d_gnt",    {31'd0, d_gnt},     32'd0);
        check("rst_d_valid",  {31'd0, d_valid},   32'd0);
        check("rst_rd_en",    {31'd0, mem_rd_en}, 32'd0);
        check("rst_wr_en",    {31'd0, mem_wr_en}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata",  d_rdata,  32'd0);
        rst = 1'b0;
        step();

        // Fetch only, latency 1
        mem_rdata = 32'h8C22_0004;
        if_req = 1'b1; if_addr = 32'h10;
        step();
        check("f_if_gnt",   {31'd0, if_gnt},    32'd1);
        check("f_rd_en",    {31'd0, mem_rd_en}, 32'd1);
        check("f_wr_en",    {31'd0, mem_wr_en}, 32'd0);
        check("f_mem_addr", mem_addr, 32'h10);
        if_req = 1'b0;
        step();
        check("f_if_valid",  {31'd0, if_valid},  32'd1);
        check("f_if_rdata",  if_rdata, 32'h8C22_0004);
        check("f_rd_en_off", {31'd0, mem_rd_en}, 32'd0);
        check("f_addr_idle", mem_addr, 32'd0);
        step();
        check("f_valid_once", {31'd0, if_valid}, 32'd0);
        check("f_rdata_hold", if_rdata, 32'h8C22_0004);

        // Simultaneous requests: data first, fetch right after completion
        mem_rdata = 32'h1111_2222;
        if_req = 1'b1; if_addr = 32'h14;
        d_rd = 1'b1; d_addr = 32'h40;
        step();
        check("sim_d_gnt",    {31'd0, d_gnt},  32'd1);
        check("sim_if_gnt0",  {31'd0, if_gnt}, 32'd0);
        check("sim_mem_addr", mem_addr, 32'h40);
        d_rd = 1'b0;
        step();
        check("sim_d_valid", {31'd0, d_valid}, 32'd1);
        check("sim_d_rdata", d_rdata, 32'h1111_2222);
        mem_rdata = 32'h3333_4444;
        step();
        check("sim_if_gnt1",   {31'd0, if_gnt}, 32'd1);
        check("sim_mem_addr2", mem_addr, 32'h14);
        if_req = 1'b0;
        step();
        check("sim_if_valid",  {31'd0, if_valid}, 32'd1);
        check("sim_if_rdata",  if_rdata, 32'h3333_4444);
        check("sim_d_rd_hold", d_rdata, 32'h1111_2222);

        // Starvation: four data grants, one fetch, then data again
        mem_rdata = 32'h0BAD_F00D;
        if_req = 1'b1; if_addr = 32'h100;
        d_rd = 1'b1; d_addr = 32'h200;
        dg_vec = '0; fg_vec = '0;
        for (int c = 1; c <= 11; c++) begin
            step();
            dg_vec[c] = d_gnt;
            fg_vec[c] = if_gnt;
            if (if_gnt) if_req = 1'b0;
        end
        d_rd = 1'b0;
        check("stv_d_gnts", {20'd0, dg_vec}, 32'h8AA);
        check("stv_f_gnts", {20'd0, fg_vec}, 32'h200);
        step();
        check("stv_last_valid", {31'd0, d_valid}, 32'd1);
        check("stv_d_rdata", d_rdata, 32'h0BAD_F00D);
        step();

        // Read+write together is a write
        mem_rdata = 32'hFFFF_0000;
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
        step();
        check("wr_d_gnt",     {31'd0, d_gnt},     32'd1);
        check("wr_wr_en",     {31'd0, mem_wr_en}, 32'd1);
        check("wr_rd_en",     {31'd0, mem_rd_en}, 32'd0);
        check("wr_mem_addr",  mem_addr,  32'h20);
        check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        d_rd = 1'b0; d_wr = 1'b0;
        dv_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (d_valid) dv_cnt++;
        end
        check("wr_valid_count", dv_cnt, 32'd1);
        check("wr_rdata_kept",  d_rdata, 32'h0BAD_F00D);

        // Reset during BUSY aborts the access
        if_req = 1'b1; if_addr = 32'h30;
        step();
        check("ab_if_gnt", {31'd0, if_gnt}, 32'd1);
        if_req = 1'b0;
        rst = 1'b1;
        step();
        check("ab_if_valid", {31'd0, if_valid},  32'd0);
        check("ab_rd_en",    {31'd0, mem_rd_en}, 32'd0);
        check("ab_mem_addr", mem_addr, 32'd0);
        check("ab_if_rdata", if_rdata, 32'd0);
        check("ab_d_rdata",  d_rdata,  32'd0);
        rst = 1'b0;
        step();
        check("ab_no_valid", {31'd0, if_valid}, 32'd0);
        mem_rdata = 32'h1234_5678;
        if_req = 1'b1; if_addr = 32'h34;
        step();
        check("ab_regnt",    {31'd0, if_gnt}, 32'd1);
        check("ab_mem_addr2", mem_addr, 32'h34);
        if_req = 1'b0;
        step();
        check("ab_revalid", {31'd0, if_valid}, 32'd1);
        check("ab_rerdata", if_rdata, 32'h1234_5678);

        // Latency 3 on the second instance
        rst = 1'b1;
        rst3 = 1'b0;
        step();
        mem_rdata = 32'hCAFE_0001;
        d_rd = 1'b1; d_addr = 32'h44;
        rd3_vec = '0; dv3_vec = '0; fg3_vec = '0; dg3_vec = '0;
        for (int c = 1; c <= 5; c++) begin
            step();
            rd3_vec[c] = mem_rd_en3;
            dv3_vec[c] = d_valid3;
            fg3_vec[c] = if_gnt3;
            dg3_vec[c] = d_gnt3;
            if (c == 2) check("l3_mem_addr", mem_addr3, 32'h44);
            if (c == 1) begin
                d_rd = 1'b0;
                if_req = 1'b1; if_addr = 32'h48;
            end
            if (if_gnt3) if_req = 1'b0;
        end
        check("l3_rd_en",   {26'd0, rd3_vec}, 32'h2E);
        check("l3_d_valid", {26'd0, dv3_vec}, 32'h10);
        check("l3_d_gnt",   {26'd0, dg3_vec}, 32'h02);
        check("l3_if_gnt",  {26'd0, fg3_vec}, 32'h20);
        check("l3_d_rdata", d_rdata3, 32'hCAFE_0001);
        check("l3_wr_en",   {31'd0, mem_wr_en3}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
